// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the pipeline state-dump transmitter.
// The slot table fixes the order in which registers appear on the output stream.
package reg_dump_pkg;

  localparam int NUM_SLOTS = 19;
  localparam int TAG_W     = 5;
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slot 0 carries the PC, so its register entry is unused.
  localparam logic [4:0] SLOT_REG [NUM_SLOTS] = '{
    5'd0,
    5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
    5'd24, 5'd25
  };

endpackage

// File: rtl/reg_dump_slot_map.sv
// Slot number to register-file address lookup.
// Slot 0 and any slot past the end of the table map to address 0.
module reg_dump_slot_map
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [TAG_W-1:0]  slot,
  output logic [ADDR_W-1:0] reg_addr
);

  always_comb begin
    reg_addr = '0;
    if (slot < TAG_W'(NUM_SLOTS)) begin
      reg_addr = ADDR_W'(SLOT_REG[slot]);
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Debug state-dump transmitter: stalls the pipeline, then streams the PC and a
// fixed list of registers as tagged words on a valid/ready interface.
//
// state   | meaning
// IDLE    | waiting for start; outputs quiet
// SEND    | word out_tag on the stream, advancing on each handshake
// DONE    | final word accepted; one-cycle done pulse
module reg_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              hold,
  output logic              done,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  input  logic [DATA_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [TAG_W-1:0]    next_slot;
  logic [ADDR_W-1:0]   map_addr;
  logic                xfer;

  assign next_slot = out_tag_q + TAG_W'(1);
  assign xfer      = out_valid_q && out_ready;

  // Address for the word loaded on the next handshake; past slot 18 this is 0.
  reg_dump_slot_map #(.ADDR_W(ADDR_W)) u_slot_map (
    .slot     (next_slot),
    .reg_addr (map_addr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SEND;
          out_valid_d = 1'b1;
          out_tag_d   = '0;
          out_data_d  = pc_in;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (out_tag_q == LAST_TAG) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
          end else begin
            out_tag_d  = next_slot;
            out_data_d = dbg_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    hold     = busy;
    done     = (state_q == ST_DONE);
    dbg_addr = (state_q == ST_SEND) ? map_addr : '0;
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: full dumps, backpressure, ignored start,
// mid-dump reset and back-to-back dumps against a hand-written slot table.
module tb_reg_dump_tx;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        hold;
  logic        done;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_tag;
  logic [31:0] out_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Hand-written expected register for each slot (slot 0 is the PC).
  int slot_exp [19] = '{0, 16, 17, 18, 19, 20, 21, 22, 23,
                        8, 9, 10, 11, 12, 13, 14, 15, 24, 25};

  reg_dump_tx #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .hold      (hold),
    .done      (done),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data)
  );

  // Register file model: register r holds 0x100 + r.
  assign dbg_rdata = 32'h100 + {27'd0, dbg_addr};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_val("idle_valid", out_valid, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_done", done, 0);
      check_val("idle_addr", dbg_addr, 0);
    end
  endtask

  // Called at a negedge. Issues start, then consumes the dump to completion
  // (or aborts with reset at abort_tag). Returns at the negedge after done.
  task automatic do_dump(input logic [31:0] pc, input bit bp, input bit hold_start,
                         input int pulse_tag, input int abort_tag);
    int          words;
    int          budget;
    int          last_hs;
    bit          stall;
    bit          finished;
    logic [4:0]  ptag;
    logic [31:0] pdata;
    logic [31:0] exp_d;
    logic [31:0] exp_a;
    words = 0; budget = 0; last_hs = 0; stall = 0; finished = 0;
    ptag = '0; pdata = '0;
    pc_in = pc;
    start = 1'b1;
    @(negedge clock);
    if (!hold_start) start = 1'b0;
    check_val("lat_valid", out_valid, 1);
    check_val("lat_tag", out_tag, 0);
    check_val("lat_busy", busy, 1);
    while (budget < 200 && !finished) begin
      if (done) begin
        check_val("done_words", words, 19);
        if (!bp) check_val("done_cycle", cyc, last_hs + 1);
        check_val("done_hold", hold, busy);
        check_val("done_valid", out_valid, 0);
        @(negedge clock);
        check_val("done_pulse", done, 0);
        check_val("busy_drop", busy, 0);
        check_val("hold_drop", hold, 0);
        finished = 1;
      end else begin
        check_val("send_busy", busy, 1);
        check_val("send_hold", hold, 1);
        check_val("send_valid", out_valid, 1);
        if (stall) begin
          check_val("stall_tag", out_tag, ptag);
          check_val("stall_data", out_data, pdata);
        end
        if (abort_tag == int'(out_tag)) begin
          out_ready = 1'b0;
          reset_n = 1'b0;
          #1;
          check_val("abort_valid", out_valid, 0);
          check_val("abort_busy", busy, 0);
          check_val("abort_hold", hold, 0);
          check_val("abort_done", done, 0);
          check_val("abort_tag", out_tag, 0);
          check_val("abort_data", out_data, 0);
          @(negedge clock);
          reset_n = 1'b1;
          for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("abort_nodone", done, 0);
            check_val("abort_idle", out_valid, 0);
          end
          finished = 1;
        end else begin
          if (pulse_tag == int'(out_tag)) start = 1'b1;
          else if (!hold_start) start = 1'b0;
          out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          if (out_ready) begin
            exp_d = (words == 0) ? pc : 32'h100 + 32'(slot_exp[words]);
            exp_a = (words < 18) ? 32'(slot_exp[words + 1]) : 32'd0;
            check_val("word_tag", out_tag, 32'(words));
            check_val("word_data", out_data, exp_d);
            check_val("word_addr", dbg_addr, exp_a);
            words++;
            last_hs = cyc;
            stall = 0;
          end else begin
            stall = 1;
            ptag = out_tag;
            pdata = out_data;
          end
          @(negedge clock);
          budget++;
        end
      end
    end
    if (!finished) check_val("timeout", 0, 1);
    out_ready = 1'b0;
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    pc_in = '0;
    #1;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_tag", out_tag, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_hold", hold, 0);
    check_val("rst_done", done, 0);
    check_val("rst_addr", dbg_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    check_idle(10);

    do_dump(32'h0000_0040, 0, 0, -1, -1);
    check_idle(2);
    do_dump(32'hDEAD_BEEC, 1, 0, -1, -1);
    check_idle(2);
    do_dump(32'h0000_1000, 0, 0, 5, -1);
    check_idle(3);
    do_dump(32'h0000_2000, 0, 0, -1, 7);
    do_dump(32'h0000_3000, 1, 0, -1, -1);
    check_idle(2);
    do_dump(32'h0000_4000, 0, 1, -1, -1);
    check_val("b2b_gap_valid", out_valid, 0);
    do_dump(32'h0000_4004, 0, 1, -1, -1);
    start = 1'b0;
    check_idle(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
